// File: rtl/apu_nn_resp_buf.sv
// apu_nn_resp_buf
// Tracks ops issued to the APU and buffers their in-order results for writeback.
// A tag FIFO holds the destination tags of ops in flight. A result FIFO holds
// returned {tag, result, flags} entries until writeback accepts them. Issue is
// throttled so that ops in flight plus buffered results never exceed MAX_OUTST.
module apu_nn_resp_buf #(
   parameter int DATA_W    = 32,
   parameter int FLAGS_W   = 5,
   parameter int TAG_W     = 6,
   parameter int MAX_OUTST = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               issue_valid_i,
   input  logic [TAG_W-1:0]   issue_tag_i,
   output logic               issue_ready_o,
   input  logic               apu_rvalid_i,
   input  logic [DATA_W-1:0]  apu_result_i,
   input  logic [FLAGS_W-1:0] apu_flags_i,
   output logic               wb_valid_o,
   input  logic               wb_ready_i,
   output logic [TAG_W-1:0]   wb_tag_o,
   output logic [DATA_W-1:0]  wb_result_o,
   output logic [FLAGS_W-1:0] wb_flags_o,
   input  logic [TAG_W-1:0]   query_tag_i,
   output logic               query_hit_o,
   output logic               busy_o,
   output logic               err_o
);

   localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W:0]   MAX_SUM  = (CNT_W + 1)'(MAX_OUTST);

   // tag FIFO state
   logic [TAG_W-1:0]   tag_mem_q [MAX_OUTST];
   logic [PTR_W-1:0]   tag_wr_q, tag_wr_d;
   logic [PTR_W-1:0]   tag_rd_q, tag_rd_d;
   logic [CNT_W-1:0]   inflight_cnt_q, inflight_cnt_d;

   // result FIFO state
   logic [TAG_W-1:0]   res_tag_mem_q   [MAX_OUTST];
   logic [DATA_W-1:0]  res_data_mem_q  [MAX_OUTST];
   logic [FLAGS_W-1:0] res_flags_mem_q [MAX_OUTST];
   logic [PTR_W-1:0]   res_wr_q, res_wr_d;
   logic [PTR_W-1:0]   res_rd_q, res_rd_d;
   logic [CNT_W-1:0]   rbuf_cnt_q, rbuf_cnt_d;

   logic               err_q, err_d;

   logic [CNT_W:0]     occ_sum_s;
   logic               issue_fire_s;
   logic               ret_fire_s;
   logic               pop_fire_s;

   // Occupancy and the three independent handshakes, all from registered state.
   always_comb begin
      occ_sum_s     = {1'b0, inflight_cnt_q} + {1'b0, rbuf_cnt_q};
      issue_ready_o = (occ_sum_s < MAX_SUM);
      busy_o        = (occ_sum_s != {(CNT_W + 1){1'b0}});
      wb_valid_o    = (rbuf_cnt_q != CNT_ZERO);
      issue_fire_s  = issue_valid_i & issue_ready_o;
      ret_fire_s    = apu_rvalid_i & (inflight_cnt_q != CNT_ZERO);
      pop_fire_s    = wb_valid_o & wb_ready_i;
      err_o         = err_q;
   end

   // Next-state for counters, pointers and the unexpected-result flag.
   always_comb begin
      tag_wr_d       = tag_wr_q;
      tag_rd_d       = tag_rd_q;
      res_wr_d       = res_wr_q;
      res_rd_d       = res_rd_q;
      inflight_cnt_d = inflight_cnt_q + CNT_W'(issue_fire_s) - CNT_W'(ret_fire_s);
      rbuf_cnt_d     = rbuf_cnt_q + CNT_W'(ret_fire_s) - CNT_W'(pop_fire_s);
      err_d          = apu_rvalid_i & (inflight_cnt_q == CNT_ZERO);
      if (issue_fire_s) begin
         tag_wr_d = tag_wr_q + PTR_ONE;
      end else begin
         tag_wr_d = tag_wr_q;
      end
      if (ret_fire_s) begin
         tag_rd_d = tag_rd_q + PTR_ONE;
         res_wr_d = res_wr_q + PTR_ONE;
      end else begin
         tag_rd_d = tag_rd_q;
         res_wr_d = res_wr_q;
      end
      if (pop_fire_s) begin
         res_rd_d = res_rd_q + PTR_ONE;
      end else begin
         res_rd_d = res_rd_q;
      end
   end

   // Control state register; reset drops every entry and any pending error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_wr_q       <= {PTR_W{1'b0}};
         tag_rd_q       <= {PTR_W{1'b0}};
         res_wr_q       <= {PTR_W{1'b0}};
         res_rd_q       <= {PTR_W{1'b0}};
         inflight_cnt_q <= CNT_ZERO;
         rbuf_cnt_q     <= CNT_ZERO;
         err_q          <= 1'b0;
      end else begin
         tag_wr_q       <= tag_wr_d;
         tag_rd_q       <= tag_rd_d;
         res_wr_q       <= res_wr_d;
         res_rd_q       <= res_rd_d;
         inflight_cnt_q <= inflight_cnt_d;
         rbuf_cnt_q     <= rbuf_cnt_d;
         err_q          <= err_d;
      end
   end

   // FIFO storage; contents are only meaningful where the counts say so.
   always_ff @(posedge clk) begin
      if (issue_fire_s) begin
         tag_mem_q[tag_wr_q] <= issue_tag_i;
      end
      if (ret_fire_s) begin
         res_tag_mem_q[res_wr_q]   <= tag_mem_q[tag_rd_q];
         res_data_mem_q[res_wr_q]  <= apu_result_i;
         res_flags_mem_q[res_wr_q] <= apu_flags_i;
      end
   end

   // Writeback view of the result-FIFO head, forced to zero when empty.
   always_comb begin
      if (wb_valid_o) begin
         wb_tag_o    = res_tag_mem_q[res_rd_q];
         wb_result_o = res_data_mem_q[res_rd_q];
         wb_flags_o  = res_flags_mem_q[res_rd_q];
      end else begin
         wb_tag_o    = {TAG_W{1'b0}};
         wb_result_o = {DATA_W{1'b0}};
         wb_flags_o  = {FLAGS_W{1'b0}};
      end
   end

   // Hazard lookup over every occupied slot of both FIFOs.
   always_comb begin
      logic [PTR_W-1:0] tag_off;
      logic [PTR_W-1:0] res_off;
      query_hit_o = 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
         tag_off     = PTR_W'(i) - tag_rd_q;
         res_off     = PTR_W'(i) - res_rd_q;
         query_hit_o = query_hit_o
                     | (({1'b0, tag_off} < inflight_cnt_q) & (tag_mem_q[i] == query_tag_i))
                     | (({1'b0, res_off} < rbuf_cnt_q) & (res_tag_mem_q[i] == query_tag_i));
      end
   end

endmodule
